// File: rtl/ca_prng_if.sv
// Bus bundle for the cellular-automaton PRNG: byte-wide write port plus read-back and status.
interface ca_prng_if;
    logic [7:0] addr;
    logic       write_en;
    logic [7:0] din;
    logic [7:0] dout;
    logic       running;

    modport master (output addr, output write_en, output din, input dout, input running);
    modport slave  (input addr, input write_en, input din, output dout, output running);
endinterface

// File: rtl/ca_prng.sv
// Ring cellular-automaton PRNG with byte seed loading, run/step control and zero recovery.
// Optional zero-recovery counter readable at BASE_ADDR+2 when CA_PRNG_STATS_EN is defined.
module ca_prng #(
    parameter int          WIDTH     = 16,
    parameter logic [7:0]  RULE      = 8'd30,
    parameter logic [63:0] SEED      = 64'h0177,
    parameter int          OUT_LSB   = 2,
    parameter logic [7:0]  BASE_ADDR = 8'd17
) (
    input  logic     clk,
    input  logic     rst,
    ca_prng_if.slave bus
);
    localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

    if (WIDTH < 8 || WIDTH > 64)       begin : g_bad_width  $error("ca_prng: WIDTH out of range");   end
    if (OUT_LSB + 7 > WIDTH - 1)       begin : g_bad_window $error("ca_prng: output window too wide"); end
    if (SEED_W == '0)                  begin : g_bad_seed   $error("ca_prng: SEED must be non-zero"); end

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] shifted;
    logic             run_q, run_d;
    logic             step_q, step_d;
    logic             seed_wr, ctrl_wr, advance, recover;

    // Seed bytes shift in from the bottom; at WIDTH=8 the new byte replaces the whole state.
    if (WIDTH > 8) begin : g_shift_wide
        assign shifted = {q_q[WIDTH-9:0], bus.din};
    end else begin : g_shift_byte
        assign shifted = bus.din;
    end

    always_comb begin
        nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            nxt[i] = RULE[{q_q[(i + WIDTH - 1) % WIDTH], q_q[i], q_q[(i + 1) % WIDTH]}];
        end
    end

    always_comb begin
        seed_wr = bus.write_en && (bus.addr == BASE_ADDR);
        ctrl_wr = bus.write_en && (bus.addr == BASE_ADDR + 8'd1);
        advance = run_q || step_q;
        recover = advance && !seed_wr && (q_q == '0);

        q_d = q_q;
        if (seed_wr) begin
            q_d = shifted;
        end else if (advance) begin
            q_d = recover ? SEED_W : nxt;
        end

        run_d  = run_q;
        step_d = 1'b0;
        if (ctrl_wr) begin
            run_d  = bus.din[0];
            step_d = bus.din[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= SEED_W;
            run_q  <= 1'b1;
            step_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            run_q  <= run_d;
            step_q <= step_d;
        end
    end

    assign bus.running = run_q;

`ifdef CA_PRNG_STATS_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (recover && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.dout = (bus.addr == BASE_ADDR + 8'd2) ? cnt_q : q_q[OUT_LSB+7:OUT_LSB];
`else
    assign bus.dout = q_q[OUT_LSB+7:OUT_LSB];
`endif
endmodule
